// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer: FSM state encoding and the
// default-width trace entry layout {pc, rd, data} (pc in the MSBs).
package wb_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'b00,
        TR_ARMED = 2'b01,
        TR_POST  = 2'b10,
        TR_DONE  = 2'b11
    } tr_state_e;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_IDX_W  = 5;
    localparam int unsigned DEF_DATA_W = 32;

    // Entry as stored in the RAM for the default widths; the top packs the same field order.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_IDX_W-1:0]  rd;
        logic [DEF_DATA_W-1:0] data;
    } tr_entry_t;

    // States in which write-back events are recorded.
    function automatic logic tr_is_capturing(tr_state_e s);
        return (s == TR_ARMED) || (s == TR_POST);
    endfunction

endpackage

// File: rtl/wb_trace_buffer_ram.sv
// Trace storage: DEPTH x WIDTH, synchronous write, asynchronous (show-ahead) read.
module wb_trace_buffer_ram #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// On-chip trace of the CPU register write-back stream with PC trigger and post-trigger window.
// Optional build macro WB_TRACE_FILTER_EN adds i_rd_mask: only events whose rd bit is set are
// stored, while trigger matching still sees every write-back event.
module wb_trace_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_arm,
    input  logic [ADDR_W-1:0]      i_trig_pc,
    input  logic                   i_wb_valid,
    input  logic [ADDR_W-1:0]      i_wb_pc,
    input  logic [IDX_W-1:0]       i_wb_rd,
    input  logic [DATA_W-1:0]      i_wb_data,
`ifdef WB_TRACE_FILTER_EN
    input  logic [2**IDX_W-1:0]    i_rd_mask,
`endif
    input  logic                   i_rd_ready,
    output logic                   o_rd_valid,
    output logic [ADDR_W-1:0]      o_rd_pc,
    output logic [IDX_W-1:0]       o_rd_rd,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic [1:0]             o_state,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_wrapped
);

    import wb_trace_buffer_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + IDX_W + DATA_W;

    tr_state_e        r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_post_cnt;
    logic             r_wrapped;

    logic             w_trig;
    logic             w_store;
    logic             w_we;
    logic             w_pop;
    logic             w_full;
    logic [ENT_W-1:0] w_rdata;

    assign w_trig = i_wb_valid && (i_wb_pc == i_trig_pc);
`ifdef WB_TRACE_FILTER_EN
    assign w_store = i_wb_valid && i_rd_mask[i_wb_rd];
`else
    assign w_store = i_wb_valid;
`endif
    // arm wins over a same-cycle capture or pop.
    assign w_we   = tr_is_capturing(r_state) && w_store && !i_arm;
    assign w_pop  = (r_state == TR_DONE) && (r_count != '0) && i_rd_ready && !i_arm;
    assign w_full = (r_count == CNT_W'(DEPTH));

    wb_trace_buffer_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_wb_pc, i_wb_rd, i_wb_data}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Capture FSM, ring pointers, occupancy and post-trigger counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= TR_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
        end else if (i_arm) begin
            r_state    <= TR_ARMED;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                // Full ring: drop the oldest entry so the window always ends at the newest.
                if (w_full) begin
                    r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                    r_wrapped <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count  <= r_count - CNT_W'(1);
            end
            unique case (r_state)
                TR_ARMED: begin
                    if (w_trig) begin
                        r_post_cnt <= '0;
                        r_state    <= (POST_TRIG == 0) ? TR_DONE : TR_POST;
                    end
                end
                TR_POST: begin
                    if (w_we) begin
                        r_post_cnt <= r_post_cnt + CNT_W'(1);
                        if (r_post_cnt + CNT_W'(1) == CNT_W'(POST_TRIG)) begin
                            r_state <= TR_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Readout view: oldest entry, gated to zero whenever nothing is available.
    always_comb begin
        o_rd_valid = (r_state == TR_DONE) && (r_count != '0);
        o_rd_pc    = '0;
        o_rd_rd    = '0;
        o_rd_data  = '0;
        if (o_rd_valid) begin
            {o_rd_pc, o_rd_rd, o_rd_data} = w_rdata;
        end
    end

    assign o_state   = r_state;
    assign o_count   = r_count;
    assign o_wrapped = r_wrapped;

endmodule
